// File: rtl/camera_pkg.sv
// camera_pkg: definitions shared by the camera controller and the pixel
// readout buffer.
//   state_t          readout FSM encoding (IDLE / CAPTURE / DRAIN)
//   ROW1 / ROW2      row identifiers as they appear on out_row
//   CAM_DATA_WIDTH   default ADC sample width
//   CAM_SAMPLES_PER_ROW  default samples per row (controller read cycles per row)
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DRAIN   = 2'b11
  } state_t;

  localparam logic ROW1 = 1'b0;
  localparam logic ROW2 = 1'b1;

  localparam int CAM_DATA_WIDTH      = 8;
  localparam int CAM_SAMPLES_PER_ROW = 5;

endpackage

// File: rtl/pixel_readout_buffer_if.sv
// pixel_readout_buffer_if: frame output stream.
//   out_data   streamed sample
//   out_row    row of out_data (ROW1 / ROW2)
//   out_valid  out_data / out_row / out_last are valid
//   out_ready  sink accepts the word
//   out_last   current word is the final word of the frame
// Handshake: a word transfers on every rising clk edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0 the source
// holds out_data, out_row and out_last stable and keeps out_valid at 1.
// out_ready may be driven independently of out_valid.
interface pixel_readout_buffer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_row;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_row,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_row,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sample_buffer.sv
// sample_buffer: DEPTH x DATA_WIDTH register array holding one frame.
//   clk    write clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index (combinational read)
//   rdata  array[raddr]
// Contents are deliberately not reset; a frame is always fully written
// before any word of it is read.
module sample_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_readout_buffer.sv
// pixel_readout_buffer: captures one frame of ADC samples for two pixel rows
// and streams it out row 1 first.
//   clk, reset        clock, asynchronous active-high reset
//   adc               conversion strobe; a sample is offered when adc = 1
//   nre1, nre2        active-low row selects (exactly one low = legal sample)
//   adc_data          ADC result, valid with adc
//   out_if            output stream (out_data/out_row/out_valid/out_ready/out_last)
//   frame_done        one-cycle pulse after the last word is accepted
//   overrun           sticky: a sample was dropped or had illegal selects
//   dbg_state         current FSM state
module pixel_readout_buffer
  import camera_pkg::*;
#(
  parameter int DATA_WIDTH      = CAM_DATA_WIDTH,
  parameter int SAMPLES_PER_ROW = CAM_SAMPLES_PER_ROW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc,
  input  logic                  nre1,
  input  logic                  nre2,
  input  logic [DATA_WIDTH-1:0] adc_data,
  pixel_readout_buffer_if.master out_if,
  output logic                  frame_done,
  output logic                  overrun,
  output state_t                dbg_state
);

  localparam int N    = SAMPLES_PER_ROW;
  localparam int CW   = $clog2(N + 1);
  localparam int PW   = $clog2(2 * N);
  localparam int LAST = 2 * N - 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt1_q, cnt1_d;
  logic [CW-1:0]   cnt2_q, cnt2_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;

  logic            we;
  logic [PW-1:0]   waddr;
  logic [DATA_WIDTH-1:0] rdata;

  logic row1_smp, row2_smp, bad_smp, draining;

  assign row1_smp = adc & ~nre1 &  nre2;
  assign row2_smp = adc &  nre1 & ~nre2;
  assign bad_smp  = adc & (nre1 == nre2);
  assign draining = (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    rptr_d  = rptr_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    we      = 1'b0;
    waddr   = '0;
    case (state_q)
      IDLE, CAPTURE: begin
        if (bad_smp) begin
          ovr_d = 1'b1;
        end else if (row1_smp) begin
          if (cnt1_q == CW'(N)) begin
            ovr_d = 1'b1;
          end else begin
            we     = 1'b1;
            waddr  = PW'(cnt1_q);
            cnt1_d = cnt1_q + CW'(1);
          end
        end else if (row2_smp) begin
          if (cnt2_q == CW'(N)) begin
            ovr_d = 1'b1;
          end else begin
            we     = 1'b1;
            waddr  = PW'(N) + PW'(cnt2_q);
            cnt2_d = cnt2_q + CW'(1);
          end
        end
        if (state_q == IDLE && (row1_smp || row2_smp)) state_d = CAPTURE;
        // Decided on the post-write counts so the frame is presented in
        // the cycle right after the final sample edge.
        if (cnt1_d == CW'(N) && cnt2_d == CW'(N)) begin
          state_d = DRAIN;
          rptr_d  = '0;
        end
      end
      DRAIN: begin
        if (adc) ovr_d = 1'b1;
        if (out_if.out_ready) begin
          if (rptr_q == PW'(LAST)) begin
            state_d = IDLE;
            cnt1_d  = '0;
            cnt2_d  = '0;
            rptr_d  = '0;
            done_d  = 1'b1;
          end else begin
            rptr_d = rptr_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      rptr_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      rptr_q  <= rptr_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (2 * N)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (adc_data),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  // Outputs are gated by DRAIN so the unreset array never leaks X outside it.
  assign out_if.out_valid = draining;
  assign out_if.out_data  = draining ? rdata : '0;
  assign out_if.out_row   = (draining && rptr_q >= PW'(N)) ? ROW2 : ROW1;
  assign out_if.out_last  = draining && (rptr_q == PW'(LAST));
  assign frame_done       = done_q;
  assign overrun          = ovr_q;
  assign dbg_state        = state_q;

endmodule
